// File: rtl/uart_tx_scheduler_if.sv
// Purpose: bundles the requester-side and transmitter-side signals of the
//          UART TX scheduler into one interface.
// Ports (signals):
//   req       requester -> sched  per-requester frame request, held until ack
//   req_data  requester -> sched  packed payloads, slice i = [i*DATA_W +: DATA_W]
//   ack       sched -> requester  one-cycle pulse, payload i captured
//   done      sched -> requester  one-cycle pulse, frame i fully transmitted
//   err       sched -> system     one-cycle pulse, start timeout, frame dropped
//   gnt_valid sched -> system     a frame is currently owned
//   gnt_id    sched -> system     owner index, valid while gnt_valid=1
//   tx_data   sched -> tx         payload held for the whole frame
//   tx_start  sched -> tx         one-cycle launch pulse
//   tx_busy   tx -> sched         transmitter is shifting a frame
// Modports: slave = scheduler side, master = requesters plus transmitter.
`timescale 1ns/1ps
interface uart_tx_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 7
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        ack;
    logic [NUM_REQ-1:0]        done;
    logic                      err;
    logic                      gnt_valid;
    logic [ID_W-1:0]           gnt_id;
    logic [DATA_W-1:0]         tx_data;
    logic                      tx_start;
    logic                      tx_busy;

    modport slave (
        input  req, req_data, tx_busy,
        output ack, done, err, gnt_valid, gnt_id, tx_data, tx_start
    );

    modport master (
        output req, req_data, tx_busy,
        input  ack, done, err, gnt_valid, gnt_id, tx_data, tx_start
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Purpose: round-robin scheduler sharing one UART transmitter between NUM_REQ
//          requesters. Launches a frame, waits for tx_busy to rise (bounded by
//          START_TIMEOUT) and fall, then holds the line idle for GAP_CYCLES.
// Ports:
//   clk  system clock, all logic on posedge
//   rst  synchronous active-high reset, priority over every transition
//   bus  uart_tx_scheduler_if.slave (requests, grants, transmitter handshake)
// All outputs are registered.
`timescale 1ns/1ps
module uart_tx_scheduler #(
    parameter int NUM_REQ       = 4,
    parameter int DATA_W        = 7,
    parameter int GAP_CYCLES    = 2,
    parameter int START_TIMEOUT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    uart_tx_scheduler_if.slave    bus
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int TMR_W = $clog2(START_TIMEOUT + 1);
    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_REQ - 1);
    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(START_TIMEOUT - 1);
    // Only reached when GAP_CYCLES > 0; the GAP state is skipped otherwise.
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE, GAP} state_t;

    state_t               state_q, state_d;
    logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic [GAP_W-1:0]     gap_q, gap_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic                 err_q, err_d;
    logic                 gnt_valid_q, gnt_valid_d;
    logic [ID_W-1:0]      gnt_id_q, gnt_id_d;
    logic [DATA_W-1:0]    tx_data_q, tx_data_d;
    logic                 tx_start_q, tx_start_d;

    logic                 win_found;
    logic [ID_W-1:0]      win_id;
    logic [ID_W-1:0]      cand;
    logic [DATA_W-1:0]    win_data;

    // Round-robin search: first requester at or after rr_ptr, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = ID_W'((int'(rr_ptr_q) + i) % NUM_REQ);
            if (!win_found && bus.req[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (win_id == ID_W'(j)) begin
                win_data = bus.req_data[j*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        timer_d     = timer_q;
        gap_d       = gap_q;
        gnt_valid_d = gnt_valid_q;
        gnt_id_d    = gnt_id_q;
        tx_data_d   = tx_data_q;
        ack_d       = '0;
        done_d      = '0;
        err_d       = 1'b0;
        tx_start_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (win_found) begin
                    tx_data_d      = win_data;
                    gnt_id_d       = win_id;
                    gnt_valid_d    = 1'b1;
                    tx_start_d     = 1'b1;
                    ack_d[win_id]  = 1'b1;
                    rr_ptr_d       = (win_id == LAST_ID) ? '0 : win_id + 1'b1;
                    timer_d        = '0;
                    state_d        = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (timer_q == TMO_LAST) begin
                    // Transmitter never answered: drop the frame, no done.
                    err_d       = 1'b1;
                    gnt_valid_d = 1'b0;
                    gap_d       = '0;
                    state_d     = (GAP_CYCLES == 0) ? IDLE : GAP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    done_d[gnt_id_q] = 1'b1;
                    gnt_valid_d      = 1'b0;
                    gap_d            = '0;
                    state_d          = (GAP_CYCLES == 0) ? IDLE : GAP;
                end
            end
            GAP: begin
                // Requests and tx_busy are ignored while the line idles.
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            timer_q     <= '0;
            gap_q       <= '0;
            ack_q       <= '0;
            done_q      <= '0;
            err_q       <= 1'b0;
            gnt_valid_q <= 1'b0;
            gnt_id_q    <= '0;
            tx_data_q   <= '0;
            tx_start_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            timer_q     <= timer_d;
            gap_q       <= gap_d;
            ack_q       <= ack_d;
            done_q      <= done_d;
            err_q       <= err_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_id_q    <= gnt_id_d;
            tx_data_q   <= tx_data_d;
            tx_start_q  <= tx_start_d;
        end
    end

    assign bus.ack       = ack_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.gnt_id    = gnt_id_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.tx_start  = tx_start_q;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Testbench for uart_tx_scheduler: a GAP_CYCLES=2 instance exercised by a
// vector table plus timeout/reset sequences, and a GAP_CYCLES=0 instance for
// back-to-back launch timing.
`timescale 1ns/1ps
module tb_uart_tx_scheduler;
    localparam int NR        = 4;
    localparam int DW        = 7;
    localparam int GAP       = 2;
    localparam int TMO       = 4;
    localparam int BUSY_LEN  = 9;
    localparam int BUSY_LEN0 = 3;
    localparam int NV        = 10;

    localparam int EV_START = 0;
    localparam int EV_DONE  = 1;
    localparam int EV_ERR   = 2;
    localparam int EV_S0    = 3;
    localparam int EV_D0    = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_scheduler_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();
    uart_tx_scheduler_if #(.NUM_REQ(NR), .DATA_W(DW)) bus0 ();

    uart_tx_scheduler #(.NUM_REQ(NR), .DATA_W(DW), .GAP_CYCLES(GAP), .START_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave)
    );
    uart_tx_scheduler #(.NUM_REQ(NR), .DATA_W(DW), .GAP_CYCLES(0), .START_TIMEOUT(TMO)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0.slave)
    );

    typedef struct {
        int          id;
        logic [DW-1:0] data;
        bit          is_err;
    } exp_t;

    typedef struct {
        bit               rst_first;
        logic [NR-1:0]    req;
        logic [NR*DW-1:0] data;
        int               exp_id;
        logic [DW-1:0]    exp_data;
    } vec_t;

    exp_t exp_q[$];
    exp_t fly_q[$];
    vec_t vecs[NV];

    int total = 0;
    int bad   = 0;
    int cyc = 0, n_start = 0, n_done = 0, n_err = 0;
    int start_cyc = 0, done_cyc = 0, err_cyc = 0, fall_cyc = 0;
    int n_s0 = 0, n_d0 = 0, s0_cyc = 0, f0_cyc = 0;
    bit prev_busy = 1'b0, prev_busy0 = 1'b0, busy_en = 1'b1;
    int tx_cnt = 0, tx_cnt0 = 0;
    bit tx_sp = 1'b0, tx_sp0 = 1'b0;

    function automatic void chk(input string nm, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, want, cyc);
        end
    endfunction

    function automatic int cnt_of(input int k);
        case (k)
            EV_START: return n_start;
            EV_DONE:  return n_done;
            EV_ERR:   return n_err;
            EV_S0:    return n_s0;
            default:  return n_d0;
        endcase
    endfunction

    task automatic wait_evt(input int k, input int target, input int budget, input string nm);
        int i;
        i = 0;
        while (cnt_of(k) < target && i < budget) begin
            @(negedge clk);
            #1;
            i++;
        end
        chk({nm, "_seen"}, int'(cnt_of(k) >= target), 1);
    endtask

    task automatic apply(input logic [NR-1:0] r, input logic [NR*DW-1:0] d);
        bus.req      = r;
        bus.req_data = d;
    endtask

    task automatic expect_frame(input int id, input logic [DW-1:0] d, input bit is_err);
        exp_t e;
        e.id = id;
        e.data = d;
        e.is_err = is_err;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        bus.req = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        busy_en = 1'b1;
        exp_q.delete();
        fly_q.delete();
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_ack"}, int'(bus.ack), 0);
        chk({tag, "_done"}, int'(bus.done), 0);
        chk({tag, "_err"}, int'(bus.err), 0);
        chk({tag, "_gnt_valid"}, int'(bus.gnt_valid), 0);
        chk({tag, "_gnt_id"}, int'(bus.gnt_id), 0);
        chk({tag, "_tx_data"}, int'(bus.tx_data), 0);
        chk({tag, "_tx_start"}, int'(bus.tx_start), 0);
    endtask

    // Transmitter models: busy rises one cycle after tx_start is seen.
    initial begin : tx_model
        bus.tx_busy = 1'b0;
        bus0.tx_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                bus.tx_busy = 1'b0;  tx_cnt = 0;  tx_sp = 1'b0;
                bus0.tx_busy = 1'b0; tx_cnt0 = 0; tx_sp0 = 1'b0;
            end else begin
                if (tx_sp && busy_en) begin
                    bus.tx_busy = 1'b1;
                    tx_cnt = BUSY_LEN - 1;
                end else if (tx_cnt > 0) begin
                    tx_cnt--;
                end else begin
                    bus.tx_busy = 1'b0;
                end
                tx_sp = bus.tx_start;
                if (tx_sp0) begin
                    bus0.tx_busy = 1'b1;
                    tx_cnt0 = BUSY_LEN0 - 1;
                end else if (tx_cnt0 > 0) begin
                    tx_cnt0--;
                end else begin
                    bus0.tx_busy = 1'b0;
                end
                tx_sp0 = bus0.tx_start;
            end
        end
    end

    // Output monitor and scoreboard consumer.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                if (prev_busy && !bus.tx_busy) fall_cyc = cyc;
                prev_busy = bus.tx_busy;
                if (bus.tx_start) begin
                    n_start++;
                    start_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        chk("start_unexpected", int'(bus.tx_start), 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("gnt_id", int'(bus.gnt_id), e.id);
                        chk("tx_data", int'(bus.tx_data), int'(e.data));
                        chk("ack_with_start", int'(bus.ack), 1 << e.id);
                        chk("gnt_valid_at_start", int'(bus.gnt_valid), 1);
                        fly_q.push_back(e);
                    end
                end else if (bus.ack != '0) begin
                    chk("ack_without_start", int'(bus.ack), 0);
                end
                if (bus.done != '0) begin
                    n_done++;
                    done_cyc = cyc;
                    if (fly_q.size() == 0) begin
                        chk("done_unexpected", int'(bus.done), 0);
                    end else begin
                        e = fly_q.pop_front();
                        chk("done_onehot", int'(bus.done), e.is_err ? 0 : (1 << e.id));
                        chk("done_after_fall", cyc - fall_cyc, 1);
                        chk("done_gnt_valid", int'(bus.gnt_valid), 0);
                        chk("done_tx_data_held", int'(bus.tx_data), int'(e.data));
                    end
                end
                if (bus.err) begin
                    n_err++;
                    err_cyc = cyc;
                    if (fly_q.size() == 0) begin
                        chk("err_unexpected", int'(bus.err), 0);
                    end else begin
                        e = fly_q.pop_front();
                        chk("err_expected", int'(bus.err), int'(e.is_err));
                        chk("err_gnt_valid", int'(bus.gnt_valid), 0);
                    end
                end
                if (bus0.tx_start) begin
                    n_s0++;
                    s0_cyc = cyc;
                end
                if (prev_busy0 && !bus0.tx_busy) f0_cyc = cyc;
                prev_busy0 = bus0.tx_busy;
                if (bus0.done != '0) n_d0++;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : main
        int s, d, e0, prev_done;
        bus.req = '0;  bus.req_data = '0;
        bus0.req = '0; bus0.req_data = '0;
        rst = 1'b1;

        vecs[0] = '{1'b1, 4'b0100, {7'h00, 7'h55, 7'h00, 7'h00}, 2, 7'h55};
        vecs[1] = '{1'b0, 4'b0100, {7'h00, 7'h55, 7'h00, 7'h00}, 2, 7'h55};
        vecs[2] = '{1'b1, 4'b1111, {7'h13, 7'h12, 7'h11, 7'h10}, 0, 7'h10};
        vecs[3] = '{1'b0, 4'b1111, {7'h13, 7'h12, 7'h11, 7'h10}, 1, 7'h11};
        vecs[4] = '{1'b0, 4'b1111, {7'h13, 7'h12, 7'h11, 7'h10}, 2, 7'h12};
        vecs[5] = '{1'b0, 4'b1111, {7'h13, 7'h12, 7'h11, 7'h10}, 3, 7'h13};
        vecs[6] = '{1'b0, 4'b1111, {7'h13, 7'h12, 7'h11, 7'h10}, 0, 7'h10};
        vecs[7] = '{1'b1, 4'b0001, {7'h23, 7'h00, 7'h00, 7'h20}, 0, 7'h20};
        vecs[8] = '{1'b0, 4'b1001, {7'h23, 7'h00, 7'h00, 7'h20}, 3, 7'h23};
        vecs[9] = '{1'b0, 4'b1001, {7'h23, 7'h00, 7'h00, 7'h20}, 0, 7'h20};

        repeat (3) @(negedge clk);
        #1;
        check_outputs_zero("rst");
        chk("rst0_gnt_valid", int'(bus0.gnt_valid), 0);
        chk("rst0_tx_start", int'(bus0.tx_start), 0);
        rst = 1'b0;

        // GAP_CYCLES=0 instance: req[1] held, relaunch 2 cycles after busy falls.
        bus0.req_data = {7'h00, 7'h00, 7'h15, 7'h00};
        bus0.req = 4'b0010;
        wait_evt(EV_S0, 1, 20, "gap0_start1");
        chk("gap0_gnt_id", int'(bus0.gnt_id), 1);
        chk("gap0_tx_data", int'(bus0.tx_data), 'h15);
        chk("gap0_ack", int'(bus0.ack), 2);
        wait_evt(EV_S0, 2, 30, "gap0_start2");
        chk("gap0_start_after_fall", s0_cyc - f0_cyc, 2);
        bus0.req = '0;
        wait_evt(EV_D0, 2, 30, "gap0_done2");

        // Vector table: single requester, contention, fairness.
        prev_done = 0;
        for (int k = 0; k < NV; k++) begin
            if (vecs[k].rst_first) begin
                do_reset();
                apply(vecs[k].req, vecs[k].data);
            end
            expect_frame(vecs[k].exp_id, vecs[k].exp_data, 1'b0);
            s = n_start;
            d = n_done;
            wait_evt(EV_START, s + 1, 40, "vec_start");
            if (!vecs[k].rst_first) chk("vec_start_spacing", start_cyc - prev_done, GAP + 1);
            if (k + 1 < NV && !vecs[k + 1].rst_first) apply(vecs[k + 1].req, vecs[k + 1].data);
            else apply('0, vecs[k].data);
            wait_evt(EV_DONE, d + 1, 40, "vec_done");
            prev_done = done_cyc;
        end

        // Start timeout: transmitter never raises busy.
        do_reset();
        busy_en = 1'b0;
        apply(4'b0010, {7'h00, 7'h00, 7'h0A, 7'h00});
        expect_frame(1, 7'h0A, 1'b1);
        s = n_start; d = n_done; e0 = n_err;
        wait_evt(EV_START, s + 1, 20, "tmo_start");
        wait_evt(EV_ERR, e0 + 1, 20, "tmo_err");
        chk("tmo_err_latency", err_cyc - start_cyc, TMO);
        chk("tmo_no_done", n_done, d);
        busy_en = 1'b1;
        expect_frame(1, 7'h0A, 1'b0);
        wait_evt(EV_START, s + 2, 20, "tmo_restart");
        chk("tmo_restart_after_gap", start_cyc - err_cyc, GAP + 1);
        bus.req = '0;
        wait_evt(EV_DONE, d + 1, 30, "tmo_retry_done");

        // Reset during WAIT_DONE.
        do_reset();
        apply(4'b0010, {7'h00, 7'h00, 7'h31, 7'h00});
        expect_frame(1, 7'h31, 1'b0);
        s = n_start; d = n_done;
        wait_evt(EV_START, s + 1, 20, "abort_start");
        bus.req = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("abort_owned_before_rst", int'(bus.gnt_valid), 1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check_outputs_zero("abort");
        rst = 1'b0;
        exp_q.delete();
        fly_q.delete();
        repeat (15) @(negedge clk);
        #1;
        chk("abort_no_done", n_done, d);
        apply(4'b1001, {7'h43, 7'h00, 7'h00, 7'h40});
        expect_frame(0, 7'h40, 1'b0);
        wait_evt(EV_START, s + 2, 20, "post_abort_start");
        bus.req = '0;
        wait_evt(EV_DONE, d + 1, 30, "post_abort_done");

        repeat (5) @(negedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size() + fly_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
